decoder_scan_ctrl: RTL and testbench
====================================

# decoder_scan_ctrl

Sequential scan controller that sits directly upstream of the 2-to-4 enabled decoder. It drives the decoder's `EN`, `A1` and `A0` inputs so that the active decoder output walks through a programmable set of channels. Each channel is held for a programmable dwell time. The block supports continuous and one-shot scanning with start/stop control, and feeds e.g. display-digit or peripheral-select strobes.

## Interface
- `DIV_W`, default 8: width of the dwell-count input and of the internal dwell counter.

- `CLK`  input  1  sole clock; all state updates on the rising edge.
- `RST`  input  1  synchronous, active-high reset.
- `START`  input  1  level-sampled request to begin a scan; acted on only in IDLE.
- `STOP`  input  1  level-sampled abort; has priority over every other event.
- `ONESHOT`  input  1  sampled at start; 1 = one pass over the mask, then stop; 0 = scan continuously.
- `MASK`  input  4  channel enable mask; bit i enables decoder output Di.
- `DIV`  input  DIV_W  dwell length minus 1; each channel is active for DIV+1 cycles.
- `EN`  output  1  decoder enable, registered.
- `A1`, `A0`  output  1 each  decoder select (channel index = {A1,A0}), registered.
- `BUSY`  output  1  high while scanning.
- `TICK`  output  1  one-cycle pulse on the first cycle each channel becomes active.
- `DONE`  output  1  one-cycle pulse when a one-shot pass completes, or when a scan ends because the mask became empty.

## Operation
- **States:** IDLE and SCAN. All outputs are registered.
- **Reset** (`RST`=1 at an edge): state becomes IDLE. `EN`=0, `A1`=0, `A0`=0, `BUSY`=0, `TICK`=0, `DONE`=0, dwell counter=0, latched oneshot flag=0. Reset overrides `START` and `STOP`. Reset mid-scan returns to IDLE in one edge and does not pulse `DONE`.
- **IDLE:** `EN`=0. `{A1,A0}` holds its last value; this is harmless because the decoder is disabled.
  - `START`=1, `STOP`=0 and `MASK`≠0: select the lowest set bit of `MASK` as the channel. Load counter←`DIV`, latch `ONESHOT`, set `EN`=1, `BUSY`=1, `TICK`=1, and go to SCAN.
  - `START` with `MASK`=0: ignored; no output change.
  - `START` and `STOP` together: stay in IDLE.
- **SCAN, counter≠0:** decrement the counter; the channel holds.
- **SCAN, counter=0 (advance):** search `MASK`, as sampled this cycle, circularly for the next set bit strictly above the current index, wrapping 3→0. The search includes the current index last.
  - Wrap-around means the search passed index 3 or came back to the current index.
  - Wrap with oneshot flag=1: finish.
  - `MASK`=0: finish.
  - Otherwise: load the new index and set counter←`DIV` (re-sampled). Pulse `TICK` for one cycle, even if the new index equals the old one (single-bit mask).
- **Finish:** `EN`=0, `BUSY`=0, `DONE`=1 for one cycle, then IDLE.
- **STOP=1 in SCAN:** at the next edge `EN`=0, `BUSY`=0, state IDLE. No `DONE` and no `TICK`. `STOP` beats a simultaneous advance.
- **`START` in SCAN:** ignored.
- **`MASK` changes during a dwell:** no effect until the next advance. The current channel completes even if its mask bit is cleared.
- **Ordering:** `EN`, `{A1,A0}` and `TICK` change on the same edge, so the select never changes while `TICK` is low inside a dwell.

## Timing
- **Start latency:** `START` sampled at edge n → `EN`=1, `BUSY`=1, `TICK`=1 visible after edge n.
- **Dwell:** exactly DIV+1 cycles per channel. With `DIV`=0 the channel changes every cycle, and `TICK` stays high continuously while a multi-bit mask is scanned.
- **One-shot length:** a pass over k set bits keeps `EN`=1 for k·(DIV+1) cycles. `DONE` follows in the next cycle, with `EN`=0 and `BUSY`=0 in that same cycle.
- **Stop latency:** `STOP` sampled at edge n → `EN`=0 after edge n.
- **Restart:** earliest restart is the cycle after returning to IDLE (one IDLE cycle minimum).

## Test plan
- **Reset:** `RST`=1 for 2 cycles with `START`=1 → all outputs 0, state IDLE; after release with `START`=0, outputs stay 0.
- **Continuous full mask:** `MASK`=4'b1111, `DIV`=2, `ONESHOT`=0, `START` pulse → `{A1,A0}` = 0,0,0,1,1,1,2,2,2,3,3,3,0… with `EN`=1. `TICK` high on cycles 1, 4, 7, 10 and 13 after start; `DONE` never asserted.
- **One-shot sparse mask:** `MASK`=4'b1010, `DIV`=1, `ONESHOT`=1 → channel 1 for 2 cycles, then channel 3 for 2 cycles. The next cycle has `EN`=0, `BUSY`=0, `DONE`=1 for exactly one cycle.
- **Stop priority:** continuous scan, assert `STOP` in the same cycle the counter reaches 0 → `EN`=0 next cycle, no `TICK`, no `DONE`. `START`+`STOP` together in IDLE → no change.
- **Mask edge cases:** `START` with `MASK`=0 → nothing happens. Scanning `MASK`=4'b0100 continuously → `{A1,A0}`=2 steadily, with `TICK` every DIV+1 cycles. Clearing `MASK` mid-dwell → the current dwell completes, then `DONE`=1 and IDLE.
- **Reset mid-operation and chained decoder check:** `RST` during SCAN → IDLE next edge, `DONE`=0. Instantiate with the decoder and check that exactly one of D0..D3 is high whenever `EN`=1, and all are 0 otherwise.

Source files
------------

// File: rtl/decoder_scan_ctrl_if.sv
// Control and decoder-drive bundle for the scan controller.
// Master drives the scan request side; slave is the controller.
interface decoder_scan_ctrl_if #(
    parameter int DIV_W = 8
);
    logic             START;
    logic             STOP;
    logic             ONESHOT;
    logic [3:0]       MASK;
    logic [DIV_W-1:0] DIV;
    logic             EN;
    logic             A1;
    logic             A0;
    logic             BUSY;
    logic             TICK;
    logic             DONE;

    modport master (
        output START, STOP, ONESHOT, MASK, DIV,
        input  EN, A1, A0, BUSY, TICK, DONE
    );

    modport slave (
        input  START, STOP, ONESHOT, MASK, DIV,
        output EN, A1, A0, BUSY, TICK, DONE
    );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving EN/A1/A0 of a 2-to-4 decoder.
// Walks the enabled channels, holding each for DIV+1 cycles.
module decoder_scan_ctrl #(
    parameter int DIV_W = 8
) (
    input  logic                CLK,
    input  logic                RST,
    decoder_scan_ctrl_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic             os_q, os_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;

    logic [1:0]       low_idx;
    logic [1:0]       nxt_idx;
    logic             nxt_wrap;
    logic [2:0]       sum;
    logic             go;
    logic             finish;

    // Lowest enabled channel, used when a scan begins
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.MASK[i]) begin
                low_idx = 2'(i);
            end
        end
    end

    // Circular search above the current index; nearest hit wins
    always_comb begin
        nxt_idx  = idx_q;
        nxt_wrap = 1'b0;
        sum      = 3'd0;
        for (int k = 4; k >= 1; k--) begin
            sum = {1'b0, idx_q} + 3'(k);
            if (bus.MASK[sum[1:0]]) begin
                nxt_idx  = sum[1:0];
                nxt_wrap = sum[2];
            end
        end
    end

    assign go     = bus.START & ~bus.STOP & (|bus.MASK);
    assign finish = (bus.MASK == 4'd0) | (nxt_wrap & os_q);

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (bus.STOP) begin
                    state_d = IDLE;
                end else if (cnt_q == '0 && finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath
    always_comb begin
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        os_d   = os_q;
        en_d   = en_q;
        busy_d = busy_q;
        tick_d = 1'b0;
        done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
                if (go) begin
                    idx_d  = low_idx;
                    cnt_d  = bus.DIV;
                    os_d   = bus.ONESHOT;
                    en_d   = 1'b1;
                    busy_d = 1'b1;
                    tick_d = 1'b1;
                end
            end
            SCAN: begin
                if (bus.STOP) begin
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DIV_W'(1);
                end else if (finish) begin
                    en_d   = 1'b0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    idx_d  = nxt_idx;
                    cnt_d  = bus.DIV;
                    tick_d = 1'b1;
                end
            end
            default: begin
                en_d   = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            os_q   <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            tick_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            os_q   <= os_d;
            en_q   <= en_d;
            busy_q <= busy_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    assign bus.EN   = en_q;
    assign bus.A1   = idx_q[1];
    assign bus.A0   = idx_q[0];
    assign bus.BUSY = busy_q;
    assign bus.TICK = tick_q;
    assign bus.DONE = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Bench for decoder_scan_ctrl: per-cycle model compare
// plus directed literal expectations.
module tb_decoder_scan_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    decoder_scan_ctrl_if #(.DIV_W(8)) bus();

    decoder_scan_ctrl #(.DIV_W(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chained 2-to-4 enabled decoder fed by the controller
    logic [3:0] dec_d;
    always_comb begin
        dec_d = 4'd0;
        if (bus.EN) begin
            dec_d[{bus.A1, bus.A0}] = 1'b1;
        end
    end

    function automatic int ch();
        return int'({bus.A1, bus.A0});
    endfunction

    task automatic lit(input string nm, input int got, input int exp);
        total++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model, updated from the inputs seen at each edge
    bit m_ok;
    bit m_act, m_en, m_busy, m_tick, m_done, m_os;
    int m_ch, m_left;

    initial begin
        int found;
        bit wrapped;
        int low;
        logic [5:0] got;
        logic [5:0] exp;
        logic [3:0] exp_d;
        m_ok = 0;
        m_act = 0;
        m_en = 0;
        m_busy = 0;
        m_tick = 0;
        m_done = 0;
        m_os = 0;
        m_ch = 0;
        m_left = 0;
        forever begin
            @(posedge clk);
            m_tick = 0;
            m_done = 0;
            if (rst) begin
                m_act = 0;
                m_en = 0;
                m_busy = 0;
                m_ch = 0;
                m_left = 0;
                m_os = 0;
                m_ok = 1;
            end else if (!m_act) begin
                if (bus.START && !bus.STOP && bus.MASK != 4'd0) begin
                    low = 0;
                    for (int i = 3; i >= 0; i--) begin
                        if (bus.MASK[i]) low = i;
                    end
                    m_ch = low;
                    m_left = int'(bus.DIV);
                    m_os = bus.ONESHOT;
                    m_act = 1;
                    m_en = 1;
                    m_busy = 1;
                    m_tick = 1;
                end
            end else if (bus.STOP) begin
                m_act = 0;
                m_en = 0;
                m_busy = 0;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
            end else begin
                found = -1;
                wrapped = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (found < 0 && bus.MASK[(m_ch + k) % 4]) begin
                        found = (m_ch + k) % 4;
                        wrapped = (m_ch + k) > 3;
                    end
                end
                if (found < 0 || (wrapped && m_os)) begin
                    m_act = 0;
                    m_en = 0;
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_ch = found;
                    m_left = int'(bus.DIV);
                    m_tick = 1;
                end
            end
            #1;
            if (m_ok) begin
                got = {bus.EN, bus.A1, bus.A0, bus.BUSY, bus.TICK, bus.DONE};
                exp = {m_en, 2'(m_ch), m_busy, m_tick, m_done};
                total++;
                if (got === exp) passed++;
                else $display("FAIL model: {EN,A,BUSY,TICK,DONE} got %b expected %b at %0t",
                              got, exp, $time);
                exp_d = m_en ? (4'd1 << m_ch) : 4'd0;
                total++;
                if (dec_d === exp_d) passed++;
                else $display("FAIL decoder: D got %b expected %b at %0t",
                              dec_d, exp_d, $time);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not end, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int fa [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
        int oa [4]  = '{1, 1, 3, 3};
        total = 0;
        passed = 0;
        rst = 1;
        bus.START = 1;
        bus.STOP = 0;
        bus.ONESHOT = 0;
        bus.MASK = 4'hf;
        bus.DIV = 8'd2;

        // Reset held with START asserted
        repeat (2) @(negedge clk);
        lit("rst_en", bus.EN, 0);
        lit("rst_busy", bus.BUSY, 0);
        lit("rst_tick", bus.TICK, 0);
        lit("rst_done", bus.DONE, 0);
        lit("rst_ch", ch(), 0);
        rst = 0;
        bus.START = 0;
        repeat (2) @(negedge clk);
        lit("idle_en", bus.EN, 0);
        lit("idle_busy", bus.BUSY, 0);

        // Continuous full mask, DIV=2
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        for (int i = 0; i < 13; i++) begin
            lit("full_ch", ch(), fa[i]);
            lit("full_tick", bus.TICK, (i % 3 == 0) ? 1 : 0);
            lit("full_en", bus.EN, 1);
            lit("full_done", bus.DONE, 0);
            if (i < 12) @(negedge clk);
        end
        repeat (2) @(negedge clk);

        // STOP on the cycle the counter reaches zero
        bus.STOP = 1;
        @(negedge clk);
        bus.STOP = 0;
        lit("stop_en", bus.EN, 0);
        lit("stop_busy", bus.BUSY, 0);
        lit("stop_tick", bus.TICK, 0);
        lit("stop_done", bus.DONE, 0);

        // START and STOP together in IDLE
        bus.START = 1;
        bus.STOP = 1;
        repeat (2) @(negedge clk);
        lit("ss_en", bus.EN, 0);
        lit("ss_busy", bus.BUSY, 0);
        lit("ss_tick", bus.TICK, 0);
        bus.START = 0;
        bus.STOP = 0;
        @(negedge clk);

        // One-shot over sparse mask, DIV=1
        bus.MASK = 4'b1010;
        bus.DIV = 8'd1;
        bus.ONESHOT = 1;
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        for (int i = 0; i < 4; i++) begin
            lit("os_ch", ch(), oa[i]);
            lit("os_en", bus.EN, 1);
            lit("os_done", bus.DONE, 0);
            @(negedge clk);
        end
        lit("os_end_en", bus.EN, 0);
        lit("os_end_busy", bus.BUSY, 0);
        lit("os_end_done", bus.DONE, 1);
        @(negedge clk);
        lit("os_done_pulse", bus.DONE, 0);

        // START with an empty mask
        bus.ONESHOT = 0;
        bus.MASK = 4'd0;
        bus.START = 1;
        @(negedge clk);
        lit("m0_en", bus.EN, 0);
        lit("m0_tick", bus.TICK, 0);
        @(negedge clk);
        bus.START = 0;
        lit("m0_busy", bus.BUSY, 0);

        // Single-bit mask, DIV=3, then mask cleared mid-dwell
        bus.MASK = 4'b0100;
        bus.DIV = 8'd3;
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        for (int i = 0; i < 10; i++) begin
            lit("one_ch", ch(), 2);
            lit("one_en", bus.EN, 1);
            lit("one_tick", bus.TICK, (i % 4 == 0) ? 1 : 0);
            if (i < 9) @(negedge clk);
        end
        bus.MASK = 4'd0;
        @(negedge clk);
        lit("clr_en1", bus.EN, 1);
        lit("clr_ch1", ch(), 2);
        @(negedge clk);
        lit("clr_en2", bus.EN, 1);
        @(negedge clk);
        lit("clr_en3", bus.EN, 0);
        lit("clr_busy", bus.BUSY, 0);
        lit("clr_done", bus.DONE, 1);
        @(negedge clk);
        lit("clr_done_pulse", bus.DONE, 0);

        // DIV=0 full mask, then reset mid-scan
        bus.MASK = 4'hf;
        bus.DIV = 8'd0;
        bus.START = 1;
        @(negedge clk);
        bus.START = 0;
        for (int i = 0; i < 3; i++) begin
            lit("d0_ch", ch(), i);
            lit("d0_tick", bus.TICK, 1);
            if (i < 2) @(negedge clk);
        end
        rst = 1;
        @(negedge clk);
        lit("mrst_en", bus.EN, 0);
        lit("mrst_busy", bus.BUSY, 0);
        lit("mrst_done", bus.DONE, 0);
        lit("mrst_ch", ch(), 0);
        rst = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
